// File: rtl/traffic_lane_model_pkg.sv
// Shared encodings for the traffic lane model: light codes, lane states,
// monitor error codes and the per-street sequence legality check.
package traffic_lane_model_pkg;

  typedef enum logic [1:0] {
    LT_GREEN   = 2'b00,
    LT_YELLOW  = 2'b01,
    LT_RED     = 2'b10,
    LT_INVALID = 2'b11
  } light_t;

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    WAIT = 2'b01,
    PASS = 2'b10
  } lane_st_t;

  localparam logic [1:0] ERR_NONE     = 2'b00;
  localparam logic [1:0] ERR_BADCODE  = 2'b01;
  localparam logic [1:0] ERR_CONFLICT = 2'b10;
  localparam logic [1:0] ERR_SEQ      = 2'b11;

  // Holding a code is always legal; otherwise only G->Y->R->G advances.
  function automatic logic seq_legal(input logic [1:0] prev, input logic [1:0] cur);
    return (prev == cur) ||
           (prev == LT_GREEN  && cur == LT_YELLOW) ||
           (prev == LT_YELLOW && cur == LT_RED)    ||
           (prev == LT_RED    && cur == LT_GREEN);
  endfunction

endpackage

// File: rtl/traffic_lane_model_lane_queue.sv
// One street's vehicle queue: saturating car counter, green pass timer,
// IDLE/WAIT/PASS state and sticky overflow flag.
module lane_queue
  import traffic_lane_model_pkg::*;
#(
  parameter int QW          = 4,
  parameter int PASS_CYCLES = 2
) (
  input  logic          CLK,
  input  logic          RESETB,
  input  logic          i_arr,
  input  logic          i_green,
  output logic [QW-1:0] o_q,
  output logic          o_busy,
  output logic          o_dep,
  output logic          o_ovf
);

  logic [QW-1:0] r_q;
  logic [7:0]    r_tmr;
  logic          r_dep;
  logic          r_ovf;
  lane_st_t      r_state;

  logic [QW-1:0] w_q_nxt;
  logic          w_full;
  logic          w_pass;
  logic          w_dep;

  assign w_full = &r_q;
  assign w_pass = (r_q != '0) && i_green;
  // The edge that would bring the timer to PASS_CYCLES is the departure edge.
  assign w_dep  = w_pass && (r_tmr == 8'(PASS_CYCLES - 1));

  always_comb begin
    w_q_nxt = r_q;
    if (w_dep && !i_arr)
      w_q_nxt = r_q - 1'b1;
    else if (i_arr && !w_dep && !w_full)
      w_q_nxt = r_q + 1'b1;
  end

  always_ff @(posedge CLK or negedge RESETB) begin
    if (!RESETB) begin
      r_q     <= '0;
      r_tmr   <= 8'd0;
      r_dep   <= 1'b0;
      r_ovf   <= 1'b0;
      r_state <= IDLE;
    end else begin
      r_q   <= w_q_nxt;
      r_dep <= w_dep;
      if (i_arr && !w_dep && w_full)
        r_ovf <= 1'b1;
      // Leaving green or emptying discards any partial pass time.
      r_tmr <= (w_pass && !w_dep) ? r_tmr + 8'd1 : 8'd0;
      if (w_q_nxt == '0)
        r_state <= IDLE;
      else if (i_green)
        r_state <= PASS;
      else
        r_state <= WAIT;
    end
  end

  assign o_q    = r_q;
  assign o_busy = (r_state != IDLE);
  assign o_dep  = r_dep;
  assign o_ovf  = r_ovf;

endmodule

// File: rtl/traffic_lane_model.sv
// Intersection model for the two-street light controller: two lane queues
// driving TA/TB plus a sticky light-protocol monitor.
module traffic_lane_model
  import traffic_lane_model_pkg::*;
#(
  parameter int QW          = 4,
  parameter int PASS_CYCLES = 2
) (
  input  logic          CLK,
  input  logic          RESETB,
  input  logic          ARR_A,
  input  logic          ARR_B,
  input  logic          LA1,
  input  logic          LA0,
  input  logic          LB1,
  input  logic          LB0,
  output logic          TA,
  output logic          TB,
  output logic [QW-1:0] QA,
  output logic [QW-1:0] QB,
  output logic          DEP_A,
  output logic          DEP_B,
  output logic          OVF_A,
  output logic          OVF_B,
  output logic          ERR,
  output logic [1:0]    ERR_CODE
);

  logic [1:0] w_la;
  logic [1:0] w_lb;
  logic [1:0] w_cause;

  logic [1:0] r_prev_la;
  logic [1:0] r_prev_lb;
  logic       r_hv;
  logic       r_err;
  logic [1:0] r_code;

  assign w_la = {LA1, LA0};
  assign w_lb = {LB1, LB0};

  lane_queue #(.QW(QW), .PASS_CYCLES(PASS_CYCLES)) u_lane_a (
    .CLK     (CLK),
    .RESETB  (RESETB),
    .i_arr   (ARR_A),
    .i_green (w_la == LT_GREEN),
    .o_q     (QA),
    .o_busy  (TA),
    .o_dep   (DEP_A),
    .o_ovf   (OVF_A)
  );

  lane_queue #(.QW(QW), .PASS_CYCLES(PASS_CYCLES)) u_lane_b (
    .CLK     (CLK),
    .RESETB  (RESETB),
    .i_arr   (ARR_B),
    .i_green (w_lb == LT_GREEN),
    .o_q     (QB),
    .o_busy  (TB),
    .o_dep   (DEP_B),
    .o_ovf   (OVF_B)
  );

  // Priority: bad code, then conflict, then sequence (only with history).
  always_comb begin
    w_cause = ERR_NONE;
    if (w_la == LT_INVALID || w_lb == LT_INVALID)
      w_cause = ERR_BADCODE;
    else if (w_la != LT_RED && w_lb != LT_RED)
      w_cause = ERR_CONFLICT;
    else if (r_hv && (!seq_legal(r_prev_la, w_la) || !seq_legal(r_prev_lb, w_lb)))
      w_cause = ERR_SEQ;
  end

  always_ff @(posedge CLK or negedge RESETB) begin
    if (!RESETB) begin
      r_prev_la <= 2'b00;
      r_prev_lb <= 2'b00;
      r_hv      <= 1'b0;
      r_err     <= 1'b0;
      r_code    <= ERR_NONE;
    end else begin
      r_prev_la <= w_la;
      r_prev_lb <= w_lb;
      r_hv      <= 1'b1;
      if (!r_err && w_cause != ERR_NONE) begin
        r_err  <= 1'b1;
        r_code <= w_cause;
      end
    end
  end

  assign ERR      = r_err;
  assign ERR_CODE = r_code;

endmodule

// File: tb/tb_traffic_lane_model.sv
// Directed vectors plus corner sequences and a closed loop against a small
// controller model for traffic_lane_model (QW=4, PASS_CYCLES=2).
module tb_traffic_lane_model;

  localparam logic [1:0] G = 2'b00, Y = 2'b01, R = 2'b10, X = 2'b11;

  logic       CLK = 1'b0;
  logic       RESETB = 1'b0;
  logic       ARR_A = 1'b0, ARR_B = 1'b0;
  logic       LA1, LA0, LB1, LB0;
  logic       TA, TB, DEP_A, DEP_B, OVF_A, OVF_B, ERR;
  logic [3:0] QA, QB;
  logic [1:0] ERR_CODE;

  logic [1:0] drv_la = R, drv_lb = R;
  logic [1:0] ctl_la, ctl_lb;
  logic       cl_mode = 1'b0;
  int         n_chk = 0, n_pass = 0;

  always #5 CLK = ~CLK;

  assign {LA1, LA0} = cl_mode ? ctl_la : drv_la;
  assign {LB1, LB0} = cl_mode ? ctl_lb : drv_lb;

  traffic_lane_model #(.QW(4), .PASS_CYCLES(2)) dut (
    .CLK(CLK), .RESETB(RESETB), .ARR_A(ARR_A), .ARR_B(ARR_B),
    .LA1(LA1), .LA0(LA0), .LB1(LB1), .LB0(LB0),
    .TA(TA), .TB(TB), .QA(QA), .QB(QB), .DEP_A(DEP_A), .DEP_B(DEP_B),
    .OVF_A(OVF_A), .OVF_B(OVF_B), .ERR(ERR), .ERR_CODE(ERR_CODE)
  );

  // Classic two-street controller: hold green while traffic, 1-cycle yellow.
  logic [1:0] r_cs;
  always_ff @(posedge CLK or negedge RESETB) begin
    if (!RESETB) r_cs <= 2'd0;
    else case (r_cs)
      2'd0: if (!TA) r_cs <= 2'd1;
      2'd1: r_cs <= 2'd2;
      2'd2: if (!TB) r_cs <= 2'd3;
      default: r_cs <= 2'd0;
    endcase
  end
  always_comb begin
    ctl_la = R; ctl_lb = R;
    case (r_cs)
      2'd0: ctl_la = G;
      2'd1: ctl_la = Y;
      2'd2: ctl_lb = G;
      default: ctl_lb = Y;
    endcase
  end

  typedef struct {
    logic aa, ab; logic [1:0] la, lb;
    int qa, qb; logic da, db;
  } vec_t;

  function automatic vec_t mk(logic aa, logic ab, logic [1:0] la, logic [1:0] lb,
                              int qa, int qb, logic da, logic db);
    vec_t v;
    v.aa = aa; v.ab = ab; v.la = la; v.lb = lb;
    v.qa = qa; v.qb = qb; v.da = da; v.db = db;
    return v;
  endfunction

  task automatic chk(input string name, input int act, input int exp);
    n_chk++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d", name, act, exp);
  endtask

  task automatic step(input logic aa, input logic ab, input logic [1:0] la, input logic [1:0] lb);
    ARR_A = aa; ARR_B = ab; drv_la = la; drv_lb = lb;
    @(posedge CLK); #1;
  endtask

  task automatic do_reset();
    ARR_A = 0; ARR_B = 0; drv_la = R; drv_lb = R;
    RESETB = 0; #7; RESETB = 1; #1;
  endtask

  vec_t vt[$];

  initial begin
    // Street A drain, partial-pass discard, arrival+departure (B held RED).
    vt.push_back(mk(1,0,R,R, 1,0, 0,0));
    vt.push_back(mk(1,0,R,R, 2,0, 0,0));
    vt.push_back(mk(1,0,R,R, 3,0, 0,0));
    vt.push_back(mk(0,0,G,R, 3,0, 0,0));
    vt.push_back(mk(0,0,G,R, 2,0, 1,0));
    vt.push_back(mk(0,0,G,R, 2,0, 0,0));
    vt.push_back(mk(0,0,G,R, 1,0, 1,0));
    vt.push_back(mk(0,0,G,R, 1,0, 0,0));
    vt.push_back(mk(0,0,G,R, 0,0, 1,0));
    vt.push_back(mk(0,0,G,R, 0,0, 0,0));
    vt.push_back(mk(1,0,Y,R, 1,0, 0,0));
    vt.push_back(mk(1,0,R,R, 2,0, 0,0));
    vt.push_back(mk(0,0,G,R, 2,0, 0,0));
    vt.push_back(mk(0,0,Y,R, 2,0, 0,0));
    vt.push_back(mk(0,0,R,R, 2,0, 0,0));
    vt.push_back(mk(0,0,G,R, 2,0, 0,0));
    vt.push_back(mk(0,0,G,R, 1,0, 1,0));
    vt.push_back(mk(1,0,G,R, 2,0, 0,0));
    vt.push_back(mk(0,0,G,R, 1,0, 1,0));
    vt.push_back(mk(1,0,G,R, 2,0, 0,0));
    vt.push_back(mk(1,0,G,R, 2,0, 1,0));

    // Reset state.
    #3;
    chk("rst_qa", QA, 0); chk("rst_qb", QB, 0);
    chk("rst_ta_tb", {TA, TB}, 0); chk("rst_dep", {DEP_A, DEP_B}, 0);
    chk("rst_ovf", {OVF_A, OVF_B}, 0); chk("rst_err", {ERR, ERR_CODE}, 0);
    @(negedge CLK); RESETB = 1; #1;

    foreach (vt[i]) begin
      step(vt[i].aa, vt[i].ab, vt[i].la, vt[i].lb);
      chk($sformatf("v%0d_qa", i), QA, vt[i].qa);
      chk($sformatf("v%0d_ta", i), TA, (vt[i].qa != 0));
      chk($sformatf("v%0d_dep_a", i), DEP_A, vt[i].da);
      chk($sformatf("v%0d_qb", i), QB, vt[i].qb);
      chk($sformatf("v%0d_dep_b", i), DEP_B, vt[i].db);
      chk($sformatf("v%0d_err", i), ERR, 0);
    end
    chk("tbl_ovf_a", OVF_A, 0);

    // Overflow on B, then arrival coinciding with departure at full.
    do_reset();
    for (int i = 0; i < 15; i++) step(0, 1, R, R);
    chk("fill_qb", QB, 15); chk("fill_tb", TB, 1); chk("fill_ovf", OVF_B, 0);
    step(0, 1, R, R);
    chk("ovf_qb", QB, 15); chk("ovf_set", OVF_B, 1);
    step(0, 1, R, G);
    chk("full_t1_qb", QB, 15); chk("full_t1_dep", DEP_B, 0);
    step(0, 1, R, G);
    chk("arrdep_qb", QB, 15); chk("arrdep_dep", DEP_B, 1);
    step(0, 0, R, G);
    chk("post_qb", QB, 15); chk("post_dep", DEP_B, 0);
    step(0, 0, R, G);
    chk("drain_qb", QB, 14); chk("drain_dep", DEP_B, 1);
    chk("ovf_sticky", OVF_B, 1); chk("ovf_a_clean", OVF_A, 0);
    // Asynchronous reset mid-operation.
    RESETB = 0; #1;
    chk("async_qb", QB, 0); chk("async_tb", TB, 0);
    chk("async_dep", DEP_B, 0); chk("async_ovf", OVF_B, 0);
    #2; RESETB = 1; @(negedge CLK);

    // Conflict, then a later bad code must not overwrite the first cause.
    do_reset();
    step(0, 0, G, G);
    chk("conf_err", ERR, 1); chk("conf_code", ERR_CODE, 2);
    step(0, 0, X, R);
    chk("conf_keep", ERR_CODE, 2);

    // Illegal GREEN->RED on A.
    do_reset();
    step(0, 0, R, R);
    step(0, 0, G, R);
    chk("seq_ok_err", ERR, 0);
    step(0, 0, R, R);
    chk("seq_err", ERR, 1); chk("seq_code", ERR_CODE, 3);

    // Bad code in the first post-reset cycle (also beats conflict).
    do_reset();
    step(0, 0, X, G);
    chk("bad_err", ERR, 1); chk("bad_code", ERR_CODE, 1);

    // First post-reset cycle skips the sequence check.
    do_reset();
    step(0, 0, G, R);
    chk("first_noseq", ERR, 0);

    // Closed loop with random arrivals, then drain.
    do_reset();
    RESETB = 0; cl_mode = 1; #2; RESETB = 1;
    @(negedge CLK);
    for (int i = 0; i < 10000; i++) begin
      ARR_A = ($urandom_range(0, 4) == 0);
      ARR_B = ($urandom_range(0, 4) == 0);
      @(negedge CLK);
    end
    ARR_A = 0; ARR_B = 0;
    chk("loop_err", {ERR, ERR_CODE}, 0);
    begin
      int cyc = 0;
      while ((QA != 0 || QB != 0) && cyc < 500) begin
        @(negedge CLK); cyc++;
      end
      chk("loop_drain_qa", QA, 0); chk("loop_drain_qb", QB, 0);
      chk("loop_drain_t", {TA, TB}, 0);
    end

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule

// File: doc/traffic_lane_model.md
Name: traffic_lane_model

Overview:
- Intersection-side counterpart of the two-street traffic light controller.
- Consumes the controller's light outputs (LA1/LA0, LB1/LB0) and produces its traffic sensor inputs (TA, TB).
- Models a vehicle queue per street. Cars arrive on pulse inputs and leave at a fixed rate while their street is green.
- Also runs a sticky safety/protocol monitor on the light codes. Used as the closed-loop environment and checker for the controller in simulation and on-board tests.

Parameters:
- QW, 4: queue counter width; capacity 2^QW-1 cars.
- PASS_CYCLES, 2: consecutive green cycles needed for one car to depart; legal range 1..255.

Ports:
- CLK  input  1  clock, rising edge.
- RESETB  input  1  reset, asynchronous, active-low.
- ARR_A  input  1  one car arrives on street A this cycle.
- ARR_B  input  1  one car arrives on street B this cycle.
- LA1  input  1  street A light code, bit 1.
- LA0  input  1  street A light code, bit 0.
- LB1  input  1  street B light code, bit 1.
- LB0  input  1  street B light code, bit 0.
- TA  output  1  traffic present on A; drives controller TA.
- TB  output  1  traffic present on B; drives controller TB.
- QA  output  QW  cars queued on A.
- QB  output  QW  cars queued on B.
- DEP_A  output  1  one-cycle pulse: a car left A.
- DEP_B  output  1  one-cycle pulse: a car left B.
- OVF_A  output  1  sticky: an arrival on A was dropped because the queue was full.
- OVF_B  output  1  sticky: an arrival on B was dropped because the queue was full.
- ERR  output  1  sticky: light protocol violation seen.
- ERR_CODE  output  2  cause of the first violation; 00 means none.

Behaviour:
- Light codes: {L1,L0}: 00 GREEN, 01 YELLOW, 10 RED, 11 INVALID.
- Reset (RESETB=0, async): QA=QB=0, TA=TB=0, DEP_*=0, OVF_*=0, ERR=0, ERR_CODE=00, pass timers=0, monitor history-valid flag=0. All outputs are registered or decoded directly from registers.
- TA = (QA!=0), TB = (QB!=0). They follow the queue registers in the same cycle with no extra delay.
- Per-lane FSM, states IDLE / WAIT / PASS:
  - IDLE: Q==0.
  - WAIT: Q>0 and light not GREEN. Timer held at 0.
  - PASS: Q>0 and light GREEN. Timer increments each cycle.
  - At the edge where the timer would reach PASS_CYCLES: Q decrements, DEP pulses for the next cycle, timer returns to 0, and the lane stays in PASS if Q remains >0.
  - Light leaving GREEN or Q reaching 0 goes to WAIT/IDLE and clears the timer. Partial pass time is discarded.
- Arrivals:
  - ARR sampled at the edge increments Q.
  - Arrival and departure at the same edge: Q unchanged, DEP still pulses.
  - Arrival with Q at max and no departure that edge: Q holds and OVF is set. OVF clears only on reset.
  - Q never wraps in either direction.
  - A departure needs Q>0, so Q cannot go negative.
- Monitor (evaluated every cycle; the first violation latches ERR=1 and ERR_CODE, later violations are ignored):
  - 01: either street code is INVALID.
  - 10: neither street is RED (conflicting right-of-way).
  - 11: illegal per-street sequence versus the previous cycle. Legal changes are GREEN->YELLOW, YELLOW->RED, RED->GREEN, or no change. Only checked once the history-valid flag is set, i.e. the first cycle after reset skips it.
  - Simultaneous causes resolve with priority 01 > 10 > 11.
- Reset asserted mid-operation: everything returns to reset values immediately. Arrivals are lost.

Decomposition:
- Shared package holds:
  - light code constants LT_GREEN/LT_YELLOW/LT_RED/LT_INVALID;
  - lane state encoding IDLE/WAIT/PASS;
  - ERR_CODE constants ERR_NONE/ERR_BADCODE/ERR_CONFLICT/ERR_SEQ.
- One sub-module, lane_queue (queue counter, pass timer, lane FSM, overflow flag), instantiated twice.
- The monitor stays in the top level.

Test Plan:
- Reset, then 3 ARR_A pulses with A RED -> QA=3, TA=1, no DEP_A. Switch A GREEN -> DEP_A pulses every 2 cycles (PASS_CYCLES=2), QA goes 2,1,0, then TA=0.
- A GREEN held for 1 cycle then YELLOW with QA=2 -> no departure, timer cleared. Next GREEN needs a full 2 cycles before the first DEP_A.
- QB=15 (QW=4) and ARR_B with B RED -> QB stays 15, OVF_B=1. ARR_B coinciding with a departure -> QB unchanged, DEP_B=1.
- Lights A=00, B=00 -> ERR=1, ERR_CODE=10. A later A=11 leaves ERR_CODE at 10.
- A goes GREEN->RED directly (B RED) -> ERR_CODE=11. LA=11 in the first post-reset cycle -> ERR_CODE=01.
- Closed loop with the controller, ARR_A/ARR_B random at 20% -> ERR stays 0 for 10k cycles and QA/QB drain whenever arrivals stop.
